// File: rtl/vector_pkg.sv
// Shared types and constants for the vector lane sequencer and its per-lane ALU.
package vector_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Beat counter width; a single-beat configuration still needs one bit.
  function automatic int unsigned beat_width(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  localparam int unsigned DEFAULT_VECTOR_SIZE = 6;
  localparam int unsigned DEFAULT_LANES       = 2;
  localparam int unsigned BEATS               = DEFAULT_VECTOR_SIZE / DEFAULT_LANES;
  localparam int unsigned BEAT_WIDTH          = beat_width(BEATS);

endpackage

// File: rtl/vector_lane_alu.sv
// Combinational single-element unsigned ALU with optional saturation and overflow flag.
module vector_lane_alu
  import vector_pkg::*;
#(
  parameter int unsigned VECTOR_DATA_WIDTH = 8
) (
  input  logic [VECTOR_DATA_WIDTH-1:0] op1,
  input  logic [VECTOR_DATA_WIDTH-1:0] op2,
  input  alu_op_t                      op,
  input  logic                         saturate,
  output logic [VECTOR_DATA_WIDTH-1:0] result,
  output logic                         overflow
);

  localparam int unsigned W   = VECTOR_DATA_WIDTH;
  localparam int unsigned SHW = (W > 1) ? $clog2(W) : 1;

  logic [W:0]     sum;
  logic [2*W-1:0] prod;
  logic [SHW-1:0] shamt;

  always_comb begin
    sum      = {1'b0, op1} + {1'b0, op2};
    prod     = {{W{1'b0}}, op1} * {{W{1'b0}}, op2};
    shamt    = op2[SHW-1:0];
    result   = '0;
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        overflow = sum[W];
        result   = (saturate && sum[W]) ? '1 : sum[W-1:0];
      end
      OP_SUB: begin
        overflow = (op1 < op2);
        result   = (saturate && overflow) ? '0 : op1 - op2;
      end
      OP_AND: result = op1 & op2;
      OP_OR:  result = op1 | op2;
      OP_XOR: result = op1 ^ op2;
      OP_SHL: result = op1 << shamt;
      OP_SHR: result = op1 >> shamt;
      OP_MUL: begin
        overflow = |prod[2*W-1:W];
        result   = (saturate && overflow) ? '1 : prod[W-1:0];
      end
      default: begin
        result   = '0;
        overflow = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/vector_lane_sequencer.sv
// Multi-beat vector execution unit: LANES elements per beat, stalls the front end while running.
module vector_lane_sequencer
  import vector_pkg::*;
#(
  parameter int unsigned VECTOR_DATA_WIDTH = 8,
  parameter int unsigned VECTOR_SIZE       = 6,
  parameter int unsigned LANES             = 2,
  parameter int unsigned ALU_CONTROL_WIDTH = 3
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          start,
  input  logic [ALU_CONTROL_WIDTH-1:0]                  aluControl,
  input  logic                                          isVectorScalarOperation,
  input  logic                                          saturate,
  input  logic [VECTOR_SIZE-1:0][VECTOR_DATA_WIDTH-1:0] vectorOperand1,
  input  logic [VECTOR_SIZE-1:0][VECTOR_DATA_WIDTH-1:0] vectorOperand2,
  input  logic [VECTOR_DATA_WIDTH-1:0]                  scalarOperand,
  output logic                                          stall,
  output logic                                          busy,
  output logic                                          done,
  output logic [VECTOR_SIZE-1:0][VECTOR_DATA_WIDTH-1:0] result,
  output logic [VECTOR_SIZE-1:0]                        zeroMask,
  output logic                                          overflow
);

  localparam int unsigned W         = VECTOR_DATA_WIDTH;
  localparam int unsigned NUM_BEATS = VECTOR_SIZE / LANES;
  localparam int unsigned BEAT_W    = beat_width(NUM_BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

  if (LANES == 0 || (VECTOR_SIZE % LANES) != 0) begin : g_bad_lanes
    $error("vector_lane_sequencer: LANES must divide VECTOR_SIZE");
  end
  if (ALU_CONTROL_WIDTH < 3) begin : g_bad_ctrl
    $error("vector_lane_sequencer: ALU_CONTROL_WIDTH must be at least 3");
  end

  seq_state_t                        state_q, state_d;
  logic [BEAT_W-1:0]                 beat_q;
  logic [VECTOR_SIZE-1:0][W-1:0]     op1_q, op2_q;
  logic [W-1:0]                      scalar_q;
  alu_op_t                           op_q;
  logic                              sat_q;
  logic                              vs_q;
  logic [VECTOR_SIZE-1:0][W-1:0]     result_q;
  logic [VECTOR_SIZE-1:0]            zero_q;
  logic                              ovf_q;

  logic                              accept;
  logic [LANES-1:0][W-1:0]           lane_a, lane_b, lane_res;
  logic [LANES-1:0]                  lane_ovf;

  assign accept   = start & (state_q != RUN);
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign stall    = reset & ((state_q == RUN) | accept);
  assign result   = result_q;
  assign zeroMask = zero_q;
  assign overflow = ovf_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (beat_q == LAST_BEAT) state_d = DONE;
      DONE:    state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane l of beat b works on element b*LANES+l; select with constant indices per beat.
  always_comb begin
    lane_a = '0;
    lane_b = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      for (int unsigned b = 0; b < NUM_BEATS; b++) begin
        if (beat_q == BEAT_W'(b)) begin
          lane_a[l] = op1_q[b*LANES+l];
          lane_b[l] = vs_q ? scalar_q : op2_q[b*LANES+l];
        end
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vector_lane_alu #(
      .VECTOR_DATA_WIDTH(W)
    ) u_alu (
      .op1     (lane_a[g]),
      .op2     (lane_b[g]),
      .op      (op_q),
      .saturate(sat_q),
      .result  (lane_res[g]),
      .overflow(lane_ovf[g])
    );
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      scalar_q <= '0;
      op_q     <= OP_ADD;
      sat_q    <= 1'b0;
      vs_q     <= 1'b0;
      result_q <= '0;
      zero_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op1_q    <= vectorOperand1;
        op2_q    <= vectorOperand2;
        scalar_q <= scalarOperand;
        op_q     <= alu_op_t'(aluControl[2:0]);
        sat_q    <= saturate;
        vs_q     <= isVectorScalarOperation;
        beat_q   <= '0;
        result_q <= '0;
        zero_q   <= '0;
        ovf_q    <= 1'b0;
      end else if (state_q == RUN) begin
        beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
        for (int unsigned i = 0; i < VECTOR_SIZE; i++) begin
          if (beat_q == BEAT_W'(i / LANES)) begin
            result_q[i] <= lane_res[i % LANES];
            zero_q[i]   <= (lane_res[i % LANES] == '0);
          end
        end
        ovf_q <= ovf_q | (|lane_ovf);
      end
    end
  end

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Self-checking bench for vector_lane_sequencer (default build plus a LANES=6 build).
module tb_vector_lane_sequencer;

  typedef logic [5:0][7:0] vec_t;

  logic       clock = 1'b0;
  logic       reset, start, start6, ivs, sat;
  logic [2:0] alu;
  vec_t       a, b;
  logic [7:0] s;

  logic stall, busy, done, ovf;
  vec_t res;
  logic [5:0] zm;
  logic stall6, busy6, done6, ovf6;
  vec_t res6;
  logic [5:0] zm6;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  vector_lane_sequencer #(
    .VECTOR_DATA_WIDTH(8), .VECTOR_SIZE(6), .LANES(2), .ALU_CONTROL_WIDTH(3)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .aluControl(alu),
    .isVectorScalarOperation(ivs), .saturate(sat),
    .vectorOperand1(a), .vectorOperand2(b), .scalarOperand(s),
    .stall(stall), .busy(busy), .done(done), .result(res), .zeroMask(zm), .overflow(ovf)
  );

  vector_lane_sequencer #(
    .VECTOR_DATA_WIDTH(8), .VECTOR_SIZE(6), .LANES(6), .ALU_CONTROL_WIDTH(3)
  ) dut6 (
    .clock(clock), .reset(reset), .start(start6), .aluControl(alu),
    .isVectorScalarOperation(ivs), .saturate(sat),
    .vectorOperand1(a), .vectorOperand2(b), .scalarOperand(s),
    .stall(stall6), .busy(busy6), .done(done6), .result(res6), .zeroMask(zm6), .overflow(ovf6)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference: element-wise unsigned arithmetic on plain integers.
  function automatic void model(input logic [2:0] op, input logic sa, input logic v,
                                input vec_t x, input vec_t y, input logic [7:0] sc,
                                output vec_t r, output logic [5:0] z, output logic o);
    longint unsigned p, q, t;
    o = 1'b0;
    for (int i = 0; i < 6; i++) begin
      p = longint'(x[i]);
      q = v ? longint'(sc) : longint'(y[i]);
      case (op)
        3'd0: begin t = p + q; if (t > 255) begin o = 1'b1; t = sa ? 255 : t - 256; end end
        3'd1: begin
          if (p < q) begin o = 1'b1; t = sa ? 0 : p + 256 - q; end
          else t = p - q;
        end
        3'd2: t = p & q;
        3'd3: t = p | q;
        3'd4: t = p ^ q;
        3'd5: t = (p << (q % 8)) % 256;
        3'd6: t = p >> (q % 8);
        default: begin t = p * q; if (t > 255) begin o = 1'b1; t = sa ? 255 : t % 256; end end
      endcase
      r[i] = t[7:0];
      z[i] = (t == 0);
    end
  endfunction

  function automatic vec_t splat(input logic [7:0] v);
    vec_t r;
    for (int i = 0; i < 6; i++) r[i] = v;
    return r;
  endfunction

  // Starts an operation on the default build and waits (bounded) for its done pulse.
  task automatic do_op(input logic [2:0] op, input logic sa, input logic v,
                       input vec_t x, input vec_t y, input logic [7:0] sc, output int lat);
    alu = op; sat = sa; ivs = v; a = x; b = y; s = sc; start = 1'b1;
    lat = 0;
    do begin
      step();
      start = 1'b0;
      lat++;
    end while (done !== 1'b1 && lat < 20);
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; start6 = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b want=0", stall); end
    step(); step();
    start = 1'b0; start6 = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got=%b%b want=00", busy, done); end
    checks++; if (res !== '0 || zm !== '0 || ovf !== 1'b0) begin errors++; $display("FAIL reset_flags got=%h/%b/%b want=0/0/0", res, zm, ovf); end
    checks++; if (busy6 !== 1'b0 || res6 !== '0 || ovf6 !== 1'b0) begin errors++; $display("FAIL reset_dut6 got=%b/%h/%b want=0/0/0", busy6, res6, ovf6); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_wrap_add();
    alu = 3'd0; sat = 1'b0; ivs = 1'b0; a = splat(8'd200); b = splat(8'd100); s = '0;
    start = 1'b1;
    #1;
    checks++; if (stall !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL wrap_t stall/done got=%b/%b want=1/0", stall, done); end
    step();
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (stall !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL wrap_run%0d stall/busy/done got=%b/%b/%b want=1/1/0", k, stall, busy, done);
      end
      step();
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL wrap_done done/busy/stall got=%b/%b/%b want=1/0/0", done, busy, stall); end
    checks++; if (res !== splat(8'd44) || ovf !== 1'b1 || zm !== 6'b0) begin errors++; $display("FAIL wrap_result got=%h/%b/%b want=%h/1/000000", res, ovf, zm, splat(8'd44)); end
    step();
    checks++; if (done !== 1'b0 || res !== splat(8'd44) || ovf !== 1'b1) begin errors++; $display("FAIL wrap_hold done/res/ovf got=%b/%h/%b want=0/%h/1", done, res, ovf, splat(8'd44)); end
  endtask

  task automatic test_sat_add();
    int lat;
    do_op(3'd0, 1'b1, 1'b0, splat(8'd200), splat(8'd100), 8'd0, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL sat_add_latency got=%0d want=4", lat); end
    checks++; if (res !== splat(8'd255) || ovf !== 1'b1) begin errors++; $display("FAIL sat_add got=%h/%b want=%h/1", res, ovf, splat(8'd255)); end
  endtask

  task automatic test_vs_sub();
    int lat;
    vec_t x, y, er;
    x = {8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
    y = splat(8'hA5);
    er = {8'd30, 8'd20, 8'd10, 8'd0, 8'd0, 8'd0};
    do_op(3'd1, 1'b1, 1'b1, x, y, 8'd30, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL vs_sub_latency got=%0d want=4", lat); end
    checks++; if (res !== er || zm !== 6'b000111 || ovf !== 1'b1) begin errors++; $display("FAIL vs_sub got=%h/%b/%b want=%h/000111/1", res, zm, ovf, er); end
  endtask

  task automatic test_random();
    int lat;
    vec_t x, y, er;
    logic [5:0] ez;
    logic eo, sa, v;
    logic [2:0] op;
    logic [7:0] sc;
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      sa = 1'($urandom_range(0, 1));
      v  = 1'($urandom_range(0, 1));
      sc = (n % 3 == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      for (int i = 0; i < 6; i++) begin
        x[i] = (n % 4 == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom);
        y[i] = (n % 4 == 1) ? 8'($urandom_range(0, 20)) : 8'($urandom);
      end
      model(op, sa, v, x, y, sc, er, ez, eo);
      do_op(op, sa, v, x, y, sc, lat);
      checks++;
      if (lat != 4 || res !== er || zm !== ez || ovf !== eo) begin
        errors++;
        $display("FAIL random%0d op=%0d sat=%b vs=%b got lat=%0d %h/%b/%b want lat=4 %h/%b/%b",
                 n, op, sa, v, lat, res, zm, ovf, er, ez, eo);
      end
      if (n % 2 == 0) step();
    end
  endtask

  task automatic test_back_to_back();
    int lat, dones;
    vec_t er;
    logic [5:0] ez;
    logic eo;
    do_op(3'd4, 1'b0, 1'b0, splat(8'h0F), splat(8'hF0), 8'd0, lat);
    checks++; if (lat != 4 || res !== splat(8'hFF)) begin errors++; $display("FAIL b2b_first got lat=%0d %h want lat=4 %h", lat, res, splat(8'hFF)); end
    do_op(3'd7, 1'b0, 1'b0, splat(8'd3), splat(8'd5), 8'd0, lat);
    checks++; if (lat != 4 || res !== splat(8'd15) || ovf !== 1'b0) begin errors++; $display("FAIL b2b_second got lat=%0d %h/%b want lat=4 %h/0", lat, res, ovf, splat(8'd15)); end
    step();
    model(3'd6, 1'b0, 1'b0, splat(8'h80), splat(8'd3), 8'd0, er, ez, eo);
    alu = 3'd6; sat = 1'b0; ivs = 1'b0; a = splat(8'h80); b = splat(8'd3); start = 1'b1;
    step();
    start = 1'b1; alu = 3'd0; a = splat(8'd1); b = splat(8'd1);
    step();
    start = 1'b0;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      if (done === 1'b1) dones++;
      step();
    end
    checks++; if (dones != 1) begin errors++; $display("FAIL b2b_run_start done_count got=%0d want=1", dones); end
    checks++; if (res !== er || ovf !== eo) begin errors++; $display("FAIL b2b_run_start_result got=%h/%b want=%h/%b", res, ovf, er, eo); end
  endtask

  task automatic test_reset_mid_run();
    int lat, dones;
    alu = 3'd0; sat = 1'b0; ivs = 1'b0; a = splat(8'd200); b = splat(8'd100); start = 1'b1;
    step();
    start = 1'b0;
    step();
    reset = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midrst_stall got=%b want=0", stall); end
    step();
    reset = 1'b1;
    checks++; if (busy !== 1'b0 || res !== '0 || ovf !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_state busy/res/ovf/done got=%b/%h/%b/%b want=0/0/0/0", busy, res, ovf, done); end
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      if (done === 1'b1) dones++;
      step();
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL midrst_no_done got=%0d want=0", dones); end
    do_op(3'd5, 1'b0, 1'b1, splat(8'h03), splat(8'd0), 8'd2, lat);
    checks++; if (lat != 4 || res !== splat(8'h0C)) begin errors++; $display("FAIL midrst_fresh got lat=%0d %h want lat=4 %h", lat, res, splat(8'h0C)); end
  endtask

  task automatic test_lanes6();
    int lat;
    step();
    alu = 3'd7; sat = 1'b0; ivs = 1'b0; a = splat(8'd16); b = splat(8'd16); start6 = 1'b1;
    lat = 0;
    do begin
      step();
      start6 = 1'b0;
      lat++;
    end while (done6 !== 1'b1 && lat < 20);
    checks++; if (lat != 2) begin errors++; $display("FAIL lanes6_latency got=%0d want=2", lat); end
    checks++; if (res6 !== '0 || zm6 !== 6'b111111 || ovf6 !== 1'b1) begin errors++; $display("FAIL lanes6_result got=%h/%b/%b want=0/111111/1", res6, zm6, ovf6); end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; start6 = 1'b0; ivs = 1'b0; sat = 1'b0;
    alu = '0; a = '0; b = '0; s = '0;
    step();
    test_reset();
    test_wrap_add();
    test_sat_add();
    test_vs_sub();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    test_lanes6();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vector_lane_sequencer.md
# vector_lane_sequencer

Multi-cycle vector execution unit for the vectorized CPU's execute stage. It accepts one vector or vector-scalar operation, processes `LANES` elements per cycle over `VECTOR_SIZE/LANES` beats, and asserts `stall` so that fetch and decode hold while it works. It generalises the single-cycle vector ALU path with three additions:
- configurable lane count;
- unsigned saturating mode;
- sticky overflow reporting and per-element zero reporting.

## Interface
Parameters:
- `VECTOR_DATA_WIDTH`, 8, element width in bits.
- `VECTOR_SIZE`, 6, elements per vector.
- `LANES`, 2, elements processed per beat. Must divide `VECTOR_SIZE`; elaboration fails otherwise.
- `ALU_CONTROL_WIDTH`, 3, operation select width.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
  - `clock` input 1: sole clock, rising edge.
  - `reset` input 1: synchronous, active-low.
- Command inputs:
  - `start` input 1: request a new operation.
  - `aluControl` input `ALU_CONTROL_WIDTH`: operation select.
  - `isVectorScalarOperation` input 1: when 1, `scalarOperand` is broadcast in place of `vectorOperand2`.
  - `saturate` input 1: unsigned saturating mode.
  - `vectorOperand1` input `[VECTOR_SIZE-1:0][VECTOR_DATA_WIDTH-1:0]`: first operand.
  - `vectorOperand2` input `[VECTOR_SIZE-1:0][VECTOR_DATA_WIDTH-1:0]`: second operand.
  - `scalarOperand` input `VECTOR_DATA_WIDTH`: broadcast operand.
- Outputs:
  - `stall` output 1: pipeline hold request.
  - `busy` output 1: high while state is RUN.
  - `done` output 1: one-cycle completion pulse.
  - `result` output `[VECTOR_SIZE-1:0][VECTOR_DATA_WIDTH-1:0]`: result vector.
  - `zeroMask` output `VECTOR_SIZE`: bit i set when `result[i]==0`.
  - `overflow` output 1: sticky per operation.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE, `start`=1: go to RUN. Latch operands, `aluControl`, `saturate` and `isVectorScalarOperation`. Clear `beat`, `result`, `zeroMask` and `overflow`.
  - RUN: process elements `beat*LANES` through `beat*LANES+LANES-1` from the latched operands.
    - Write those elements of `result`, the matching `zeroMask` bits, and OR any lane overflow into `overflow`.
    - Increment `beat`. At the last beat (`VECTOR_SIZE/LANES-1`), go to DONE.
  - DONE: `done`=1 for exactly this cycle.
    - `start`=1: accept exactly as from IDLE and go to RUN.
    - Otherwise go to IDLE.
  - `start` during RUN is ignored.
- `aluControl` encoding. All operations are unsigned; op2 is `vectorOperand2[i]` or the broadcast scalar.
  - 000 add: overflow on carry-out.
  - 001 sub: overflow on borrow.
  - 010 and.
  - 011 or.
  - 100 xor.
  - 101 shift left by op2 low `$clog2(VECTOR_DATA_WIDTH)` bits: no overflow.
  - 110 logical shift right by the same amount: no overflow.
  - 111 multiply: result is the low `VECTOR_DATA_WIDTH` bits; overflow when any high product bit is nonzero.
- Saturation:
  - `saturate`=1: an add or mul overflow clamps the element to all-ones, and a sub borrow clamps it to 0.
  - `overflow` is still set.
  - Logic ops and shifts ignore `saturate`.
- `result`, `zeroMask` and `overflow` hold their values from DONE until the next accepted `start`.

## Timing
- Reset (`reset`=0 at a clock edge) forces:
  - state IDLE, `beat`=0;
  - `result`=0, `zeroMask`=0, `overflow`=0;
  - `done`=0, `busy`=0.
  - This applies mid-RUN: the operation is abandoned and no `done` is produced.
- `stall` is combinational: `(state==RUN) | (start & state!=RUN)`. It is 0 during reset.
- Latency: with `start` sampled at edge t, RUN spans cycles t+1 to t+B, where B=`VECTOR_SIZE/LANES`. `done` is high in cycle t+B+1, and `result` is stable from that cycle.
- Throughput: back-to-back starts issued in DONE give one operation every B+1 cycles.
- With B=1, RUN lasts one cycle; at this point the RUN-to-DONE transition and the first-beat logic coincide.

## Structure
- Shared package `vector_pkg` holds:
  - `alu_op_t` enum for the eight encodings;
  - `seq_state_t` enum (IDLE, RUN, DONE);
  - the `BEATS` constant and the `beat` counter width `$clog2(BEATS)` (minimum 1).
- Sub-module `vector_lane_alu`: combinational, one element. Inputs are op1, op2, op, saturate; outputs are result, overflow. It is instantiated `LANES` times via generate.
- Operand latches, FSM, beat counter and result/flag registers live in the top module.

## Test plan
Defaults apply (W=8, SIZE=6, LANES=2) unless stated.
- Wrap add: all op1=200, all op2=100, `saturate`=0, start at t. Required:
  - `result` all 44, `overflow`=1, `zeroMask`=0;
  - `done` only at t+4;
  - `stall` high t through t+3.
- Saturating add: same operands with `saturate`=1 -> `result` all 255, `overflow`=1.
- Vector-scalar saturating sub: op1={60,50,40,30,20,10} (element 5 down to 0), scalar=30, `saturate`=1. Required: `result`={30,20,10,0,0,0}, `zeroMask`=6'b000111, `overflow`=1.
- Back-to-back: second start in the DONE cycle is accepted and its `done` arrives 4 cycles later. A start pulsed during RUN is ignored, with no extra `done`.
- Reset mid-RUN: drive `reset`=0 at beat 1. Next cycle:
  - `busy`=0, `result`=0, `overflow`=0;
  - no `done` produced;
  - a fresh start completes normally.
- LANES=6 build: mul of all 16 by all 16 -> `result` all 0, `zeroMask`=6'b111111, `overflow`=1, `done` at t+2.
